// File: rtl/neosd_pkg.sv
// Shared types and constants for the neosd Wishbone DMA initiator.
package neosd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_ACK,
    S_PUSH,
    S_DONE
  } dma_state_e;

  localparam logic [3:0]  WB_SEL_ALL          = 4'hF;
  localparam logic [31:0] WORD_BYTES          = 32'd4;
  localparam int          DMA_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/neosd_dma_timeout.sv
// Bus-response watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th enabled cycle is reached.
module neosd_dma_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + 16'd1;
  end

  assign expired = enable && (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/neosd_wb_dma.sv
// Single-outstanding Wishbone pipelined initiator moving 32-bit words between
// the SD stream and memory. Read direction is built only with NEOSD_DMA_READ_EN.
module neosd_wb_dma
  import neosd_pkg::*;
#(
  parameter int TIMEOUT = DMA_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_start_i,
  input  logic             cmd_dir_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [CNT_W-1:0] cmd_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [31:0]      m_dat_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_stall_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic [31:0]      wb_dat_i
);

  dma_state_e       state, state_nxt;
  logic [31:0]      addr, wdat;
  logic [CNT_W-1:0] rem;
  logic             dir, err, tmo, last;

  assign last = (rem == CNT_W'(1));

  neosd_dma_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state != S_ACK),
    .enable  (state == S_ACK),
    .expired (tmo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // err beats ack, ack beats timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_start_i) begin
          if (cmd_len_i == '0) state_nxt = S_DONE;
`ifdef NEOSD_DMA_READ_EN
          else if (cmd_dir_i)  state_nxt = S_REQ;
`else
          else if (cmd_dir_i)  state_nxt = S_DONE;
`endif
          else                 state_nxt = S_FETCH;
        end
      end
      S_FETCH: if (s_valid_i) state_nxt = S_REQ;
      S_REQ:   if (!wb_stall_i) state_nxt = S_ACK;
      S_ACK: begin
        if (wb_err_i) state_nxt = S_DONE;
        else if (wb_ack_i) begin
`ifdef NEOSD_DMA_READ_EN
          if (dir) state_nxt = S_PUSH;
          else
`endif
          state_nxt = last ? S_DONE : S_FETCH;
        end
        else if (tmo) state_nxt = S_DONE;
      end
`ifdef NEOSD_DMA_READ_EN
      S_PUSH:  if (m_ready_i) state_nxt = (rem == '0) ? S_DONE : S_REQ;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    s_ready_o = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = '0;
    m_valid_o = 1'b0;
    case (state)
      S_FETCH: begin
        busy_o    = 1'b1;
        s_ready_o = 1'b1;
      end
      S_REQ: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = !dir;
        wb_sel_o = WB_SEL_ALL;
      end
      S_ACK: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_we_o  = !dir;
      end
      S_PUSH: begin
        busy_o = 1'b1;
`ifdef NEOSD_DMA_READ_EN
        m_valid_o = 1'b1;
`endif
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr <= '0;
      wdat <= '0;
      rem  <= '0;
      dir  <= 1'b0;
      err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_start_i) begin
          addr <= {cmd_addr_i[31:2], 2'b00};
          rem  <= cmd_len_i;
          dir  <= cmd_dir_i;
`ifdef NEOSD_DMA_READ_EN
          err  <= 1'b0;
`else
          err  <= cmd_dir_i;
`endif
        end
        S_FETCH: if (s_valid_i) wdat <= s_dat_i;
        S_ACK: begin
          if (wb_err_i) err <= 1'b1;
          else if (wb_ack_i) begin
            addr <= addr + WORD_BYTES;
            rem  <= rem - CNT_W'(1);
          end
          else if (tmo) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef NEOSD_DMA_READ_EN
  logic [31:0] rdat;

  always_ff @(posedge clk_i) begin
    if (rst_i) rdat <= '0;
    else if (state == S_ACK && dir && !wb_err_i && wb_ack_i) rdat <= wb_dat_i;
  end

  assign m_dat_o = rdat;

  logic unused_bits;
  assign unused_bits = ^cmd_addr_i[1:0];
`else
  assign m_dat_o = '0;

  logic unused_bits;
  assign unused_bits = ^{cmd_addr_i[1:0], m_ready_i, wb_dat_i};
`endif

  assign wb_adr_o = addr;
  assign wb_dat_o = wdat;
  assign err_o    = err;

endmodule

// File: tb/tb_neosd_wb_dma.sv
// Directed bench for neosd_wb_dma: a negedge Wishbone slave / stream model
// plus per-scenario tasks with hand-computed expectations.
module tb_neosd_wb_dma;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        cmd_start_i = 1'b0, cmd_dir_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] s_dat_i = '0;
  logic        s_valid_i = 1'b0, s_ready_o;
  logic [31:0] m_dat_o;
  logic        m_valid_o, m_ready_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  neosd_wb_dma #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_start_i(cmd_start_i), .cmd_dir_i(cmd_dir_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_dat_i(s_dat_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_dat_o(m_dat_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i)
  );

  int n_tests = 0, n_fail = 0;

  int  stall_left, err_at, req_n, pend_num, stb_cyc, stb_chg, ack_cyc, done_cnt, cyc_cnt;
  bit  no_ack, pend, in_req, take_pend;
  logic [31:0] pend_adr, req_adr0, req_dat0;
  logic [31:0] adr_q[$], dat_q[$], m_q[$], src[$];
  logic        we_q[$];

  // Slave answers one cycle after an accepted strobe; read data = addr ^ 5A5A0000.
  always @(negedge clk) begin
    if (take_pend && src.size() > 0) src.delete(0);
    s_valid_i = (src.size() > 0);
    s_dat_i   = s_valid_i ? src[0] : 32'h0;
    take_pend = s_valid_i && s_ready_o;

    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'hDEADBEEF;
    if (pend) begin
      if (err_at != 0 && pend_num == err_at) wb_err_i = 1'b1;
      else if (!no_ack) begin
        wb_ack_i = 1'b1;
        wb_dat_i = pend_adr ^ 32'h5A5A0000;
      end
    end
    pend = 1'b0;
    wb_stall_i = 1'b0;
    if (wb_stb_o) begin
      stb_cyc++;
      if (!in_req) begin
        req_adr0 = wb_adr_o; req_dat0 = wb_dat_o; in_req = 1'b1;
      end else if (wb_adr_o !== req_adr0 || wb_dat_o !== req_dat0) stb_chg++;
      if (stall_left > 0) begin
        wb_stall_i = 1'b1; stall_left--;
      end else begin
        pend = 1'b1; in_req = 1'b0; req_n++; pend_num = req_n; pend_adr = wb_adr_o;
        adr_q.push_back(wb_adr_o); dat_q.push_back(wb_dat_o); we_q.push_back(wb_we_o);
      end
    end
    if (wb_cyc_o) cyc_cnt++;
    if (wb_cyc_o && !wb_stb_o) ack_cyc++;
    if (done_o) done_cnt++;
    if (m_valid_o && m_ready_i) m_q.push_back(m_dat_o);
  end

  task automatic clear_logs();
    stall_left = 0; err_at = 0; req_n = 0; pend_num = 0; stb_cyc = 0; stb_chg = 0;
    ack_cyc = 0; done_cnt = 0; cyc_cnt = 0; no_ack = 1'b0; in_req = 1'b0; take_pend = 1'b0;
    adr_q.delete(); dat_q.delete(); we_q.delete(); m_q.delete(); src.delete();
  endtask

  // Returns in cycle 1 (the cycle after the start was sampled).
  task automatic start_xfer(input logic dir, input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    cmd_dir_i = dir; cmd_addr_i = addr; cmd_len_i = len; cmd_start_i = 1'b1;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int max, output int cyc, output bit ok);
    cyc = c0;
    while (!done_o && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = done_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o} !== 12'h0) begin
      n_fail++; $display("FAIL reset_ctrl got=%h exp=000",
        {busy_o, done_o, err_o, s_ready_o, m_valid_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o});
    end
    n_tests++;
    if ({wb_adr_o, wb_dat_o, m_dat_o} !== 96'h0) begin
      n_fail++; $display("FAIL reset_bus adr=%h dat=%h mdat=%h exp=0", wb_adr_o, wb_dat_o, m_dat_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    clear_logs();
    src.push_back(32'h12345678);
    start_xfer(1'b0, 32'h0000_0023, 16'd1);
    n_tests++;
    if ({busy_o, s_ready_o, wb_cyc_o} !== 3'b110) begin
      n_fail++; $display("FAIL single_c1 busy/rdy/cyc=%b exp=110", {busy_o, s_ready_o, wb_cyc_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'h7F || wb_adr_o !== 32'h20 || wb_dat_o !== 32'h12345678) begin
      n_fail++; $display("FAIL single_c2 ctl=%b adr=%h dat=%h exp=1111111 00000020 12345678",
        {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, wb_adr_o, wb_dat_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({wb_cyc_o, wb_stb_o, done_o} !== 3'b100) begin
      n_fail++; $display("FAIL single_c3 cyc/stb/done=%b exp=100", {wb_cyc_o, wb_stb_o, done_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({done_o, busy_o, err_o, wb_cyc_o} !== 4'b1000) begin
      n_fail++; $display("FAIL single_c4 done/busy/err/cyc=%b exp=1000", {done_o, busy_o, err_o, wb_cyc_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({done_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL single_c5 done/busy=%b exp=00", {done_o, busy_o});
    end
  endtask

  task automatic test_write_burst();
    int cyc; bit ok;
    clear_logs();
    src.push_back(32'hA0); src.push_back(32'hA1); src.push_back(32'hA2);
    start_xfer(1'b0, 32'h1000, 16'd3);
    wait_done(1, 40, cyc, ok);
    n_tests++;
    if (!ok || cyc != 10) begin
      n_fail++; $display("FAIL burst_latency done=%0d cyc=%0d exp=1 10", ok, cyc);
    end
    @(posedge clk); #1;
    n_tests++;
    if (adr_q.size() != 3 || adr_q[0] !== 32'h1000 || adr_q[1] !== 32'h1004 || adr_q[2] !== 32'h1008) begin
      n_fail++; $display("FAIL burst_adr n=%0d got=%p exp=1000 1004 1008", adr_q.size(), adr_q);
    end
    n_tests++;
    if (dat_q.size() != 3 || dat_q[0] !== 32'hA0 || dat_q[1] !== 32'hA1 || dat_q[2] !== 32'hA2 ||
        we_q[0] !== 1'b1 || we_q[1] !== 1'b1 || we_q[2] !== 1'b1) begin
      n_fail++; $display("FAIL burst_dat got=%p we=%p exp=a0 a1 a2 we=1", dat_q, we_q);
    end
    n_tests++;
    if (done_cnt != 1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL burst_done done_cnt=%0d err=%b exp=1 0", done_cnt, err_o);
    end
  endtask

  task automatic test_stall();
    int cyc; bit ok;
    clear_logs();
    src.push_back(32'hCAFE0001);
    stall_left = 4;
    start_xfer(1'b0, 32'h2000, 16'd1);
    wait_done(1, 40, cyc, ok);
    n_tests++;
    if (!ok || cyc != 8) begin
      n_fail++; $display("FAIL stall_latency done=%0d cyc=%0d exp=1 8", ok, cyc);
    end
    @(posedge clk); #1;
    n_tests++;
    if (stb_cyc != 5 || stb_chg != 0) begin
      n_fail++; $display("FAIL stall_stb stb_cyc=%0d changes=%0d exp=5 0", stb_cyc, stb_chg);
    end
    n_tests++;
    if (err_o !== 1'b0 || done_cnt != 1 || adr_q.size() != 1 || dat_q[0] !== 32'hCAFE0001) begin
      n_fail++; $display("FAIL stall_result err=%b done_cnt=%0d reqs=%0d exp=0 1 1", err_o, done_cnt, adr_q.size());
    end
  endtask

  task automatic test_wb_error();
    int cyc; bit ok;
    clear_logs();
    src.push_back(32'hE0); src.push_back(32'hE1); src.push_back(32'hE2); src.push_back(32'hE3);
    err_at = 2;
    start_xfer(1'b0, 32'h3000, 16'd4);
    wait_done(1, 60, cyc, ok);
    n_tests++;
    if (!ok || cyc != 7 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_done done=%0d cyc=%0d err=%b exp=1 7 1", ok, cyc, err_o);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (req_n != 2 || done_cnt != 1 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_no_third reqs=%0d done_cnt=%0d err=%b exp=2 1 1", req_n, done_cnt, err_o);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    clear_logs();
    src.push_back(32'h7777);
    no_ack = 1'b1;
    start_xfer(1'b0, 32'h4000, 16'd1);
    wait_done(1, 60, cyc, ok);
    n_tests++;
    if (!ok || cyc != 11 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done done=%0d cyc=%0d err=%b exp=1 11 1", ok, cyc, err_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ack_cyc != 8 || done_cnt != 1) begin
      n_fail++; $display("FAIL timeout_ack_cycles ack_cyc=%0d done_cnt=%0d exp=8 1", ack_cyc, done_cnt);
    end
  endtask

  task automatic test_len_zero();
    clear_logs();
    start_xfer(1'b0, 32'h5000, 16'd0);
    n_tests++;
    if ({done_o, busy_o, err_o} !== 3'b100) begin
      n_fail++; $display("FAIL len0_done done/busy/err=%b exp=100", {done_o, busy_o, err_o});
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (cyc_cnt != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL len0_nobus cyc_cnt=%0d done_cnt=%0d exp=0 1", cyc_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    clear_logs();
    src.push_back(32'h6666);
    no_ack = 1'b1;
    start_xfer(1'b0, 32'h6000, 16'd1);
    for (int i = 0; i < 10 && !hit; i++) begin
      if (wb_cyc_o && !wb_stb_o) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL rstmid_reach_ack got=0 exp=1");
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o} !== 12'h0 ||
        {wb_adr_o, wb_dat_o, m_dat_o} !== 96'h0) begin
      n_fail++; $display("FAIL rstmid_outputs ctl=%h adr=%h dat=%h exp=0",
        {busy_o, done_o, err_o, s_ready_o, m_valid_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o}, wb_adr_o, wb_dat_o);
    end
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_done done_cnt=%0d busy=%b exp=0 0", done_cnt, busy_o);
    end
  endtask

  task automatic test_start_busy();
    int cyc; bit ok;
    clear_logs();
    src.push_back(32'hB0); src.push_back(32'hB1);
    start_xfer(1'b0, 32'h7000, 16'd2);
    cmd_addr_i = 32'h8000; cmd_len_i = 16'd5; cmd_dir_i = 1'b0; cmd_start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_start_i = 1'b0;
    wait_done(4, 40, cyc, ok);
    n_tests++;
    if (!ok || cyc != 7) begin
      n_fail++; $display("FAIL busy_latency done=%0d cyc=%0d exp=1 7", ok, cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (adr_q.size() != 2 || adr_q[0] !== 32'h7000 || adr_q[1] !== 32'h7004 || done_cnt != 1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignored adr=%p done_cnt=%0d busy=%b exp=7000 7004 1 0", adr_q, done_cnt, busy_o);
    end
  endtask

`ifdef NEOSD_DMA_READ_EN
  task automatic test_read();
    int cyc; bit ok; bit seen = 1'b0; bit stable = 1'b1;
    clear_logs();
    m_ready_i = 1'b0;
    start_xfer(1'b1, 32'hFFFF_FFFC, 16'd2);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (m_valid_o) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL read_first_valid got=0 exp=1");
    end
    for (int i = 0; i < 5; i++) begin
      if (!m_valid_o || m_dat_o !== 32'hA5A5FFFC || wb_cyc_o) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_tests++;
    if (!stable) begin
      n_fail++; $display("FAIL read_hold valid=%b mdat=%h cyc=%b exp=1 a5a5fffc 0", m_valid_o, m_dat_o, wb_cyc_o);
    end
    m_ready_i = 1'b1;
    wait_done(0, 40, cyc, ok);
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    n_tests++;
    if (adr_q.size() != 2 || adr_q[0] !== 32'hFFFF_FFFC || adr_q[1] !== 32'h0 || we_q[0] !== 1'b0 || we_q[1] !== 1'b0) begin
      n_fail++; $display("FAIL read_adr got=%p we=%p exp=fffffffc 00000000 we=0", adr_q, we_q);
    end
    n_tests++;
    if (m_q.size() != 2 || m_q[0] !== 32'hA5A5FFFC || m_q[1] !== 32'h5A5A0000) begin
      n_fail++; $display("FAIL read_stream got=%p exp=a5a5fffc 5a5a0000", m_q);
    end
    n_tests++;
    if (!ok || done_cnt != 1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL read_done done=%0d done_cnt=%0d err=%b exp=1 1 0", ok, done_cnt, err_o);
    end
  endtask
`else
  task automatic test_read();
    clear_logs();
    start_xfer(1'b1, 32'h9000, 16'd2);
    n_tests++;
    if ({done_o, err_o, busy_o} !== 3'b110) begin
      n_fail++; $display("FAIL read_disabled done/err/busy=%b exp=110", {done_o, err_o, busy_o});
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (cyc_cnt != 0 || m_valid_o !== 1'b0 || m_dat_o !== 32'h0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL read_disabled_bus cyc_cnt=%0d mvalid=%b mdat=%h err=%b exp=0 0 0 1",
        cyc_cnt, m_valid_o, m_dat_o, err_o);
    end
  endtask
`endif

  initial begin
    clear_logs();
    test_reset();
    test_single_write();
    test_write_burst();
    test_stall();
    test_wb_error();
    test_timeout();
    test_len_zero();
    test_reset_mid();
    test_start_busy();
    test_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neosd_wb_dma.md
# neosd_wb_dma

Wishbone pipelined initiator that moves 32-bit words between the SD data path and system memory. It is the bus-master counterpart to the neosd register-slave port. Software programs a transfer; this block then issues single-word Wishbone cycles with one request outstanding at a time. In write direction it drains an incoming stream into memory. In read direction it fetches memory words into an outgoing stream.

## Interface
- TIMEOUT, 255: cycles to wait for ack/err before aborting; legal range 1..65535
- CNT_W, 16: width of the word-count field
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cmd_start_i  in  1  start pulse; sampled only in IDLE
- cmd_dir_i  in  1  0 = stream→memory (WB write), 1 = memory→stream (WB read)
- cmd_addr_i  in  32  byte base address; bits [1:0] ignored
- cmd_len_i  in  CNT_W  word count; 0 = no bus activity
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag; cleared on accepted start
- s_dat_i / s_valid_i / s_ready_o  in/in/out  32/1/1  input stream, used for writes
- m_dat_o / m_valid_o / m_ready_i  out/out/in  32/1/1  output stream, used for reads
- wb_adr_o  out  32  word-aligned address
- wb_dat_o  out  32  write data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte select; always 4'hF while stb_o is high
- wb_stb_o, wb_cyc_o  out  1  strobe, cycle
- wb_stall_i, wb_ack_i, wb_err_i  in  1  slave handshake
- wb_dat_i  in  32  read data

## Operation
- The FSM has these states: IDLE, FETCH, REQ, ACK, PUSH, DONE.
- IDLE with cmd_start_i:
  - Latches the word-aligned address, the length, and the direction.
  - Clears err_o.
  - Sets busy_o.
  - If len = 0, goes to DONE. Otherwise goes to FETCH if dir = 0, or REQ if dir = 1.
- FETCH:
  - s_ready_o = 1.
  - On s_valid_i, captures s_dat_i into wb_dat_o and goes to REQ.
- REQ:
  - cyc_o = stb_o = 1; we_o = !dir.
  - If !wb_stall_i, goes to ACK; stb_o drops next cycle and cyc_o stays high.
- ACK:
  - cyc_o = 1.
  - On wb_err_i, sets err_o and goes to DONE. err wins over a simultaneous ack.
  - On wb_ack_i, advances the address by 4 (modulo 2^32 wrap) and decrements remaining.
    - Write direction: goes to DONE if remaining hits 0, else FETCH.
    - Read direction: captures wb_dat_i into m_dat_o and goes to PUSH.
  - The timeout counter resets on entry to ACK. When it reaches TIMEOUT, sets err_o and goes to DONE.
- PUSH:
  - m_valid_o = 1; m_dat_o is held stable.
  - On m_ready_i, goes to DONE if remaining = 0, else REQ.
- DONE:
  - done_o = 1 for one cycle; busy_o drops in the same cycle.
  - Returns to IDLE.
- cyc_o is high only in REQ and ACK, so the bus is released while waiting on either stream.
- cmd_start_i outside IDLE is ignored.
- Reset mid-transfer:
  - The next edge returns the block to IDLE and drops cyc_o/stb_o.
  - No done_o pulse; words already written are not rolled back.

## Timing
- Reset value of every output is 0, including the data and address buses.
- Single write, s_valid_i already high, zero stall, slave acks one cycle after stb:
  - Start sampled at cycle 0.
  - FETCH handshake at cycle 1.
  - stb_o at cycle 2.
  - ack at cycle 3.
  - done_o at cycle 4.
- Steady-state write: 3 cycles per word. Steady-state read: 3 cycles per word (REQ, ACK, PUSH) plus stall and backpressure.
- stb_o stays asserted with stable adr/dat/we/sel for as long as wb_stall_i is high. Stall cycles do not count toward the timeout.
- An ack or err arriving outside ACK is ignored.

## Configuration
- NEOSD_DMA_READ_EN defined:
  - The read direction (REQ→ACK→PUSH path, m_* stream) is present.
- Not defined:
  - m_valid_o is tied to 0 and m_dat_o to 0.
  - A start with dir = 1 goes straight to DONE with err_o set and no bus activity.

## Structure
- Package neosd_pkg holds:
  - the DMA state enum;
  - WB_SEL_ALL (4'hF);
  - WORD_BYTES (4);
  - the default TIMEOUT constant.
- Sub-module neosd_dma_timeout contains the timeout counter. Its inputs are clear, enable, and the TIMEOUT parameter; its output is expired.

## Test plan
- Write, len = 3, addr 0x1000, stream 0xA0, 0xA1, 0xA2, zero-stall slave:
  - Writes land at 0x1000, 0x1004, 0x1008.
  - Exactly one done_o pulse; err_o = 0.
- Read, len = 2, addr 0xFFFFFFFC:
  - Read addresses are 0xFFFFFFFC then 0x00000000.
  - m_dat_o delivers memory contents in order, with m_ready_i held low for 5 cycles on the first word.
- Stall on the 1st word for 4 cycles:
  - stb_o is held for 5 cycles with constant adr/dat.
  - No timeout.
- Error and timeout cases:
  - Slave raises wb_err_i on the 2nd of 4 words: err_o = 1, done_o pulses, and no 3rd request is issued.
  - With TIMEOUT = 8 and no ack, err_o sets after 8 ACK cycles.
- len = 0 start: done_o pulses 1 cycle later and cyc_o never rises.
- rst_i asserted while in ACK: next cycle all outputs are 0 and busy_o = 0.
- A start during busy is ignored.
